// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur runner game-state logic.
// The optional high-score compare helper is only instantiated when GAME_CTRL_HISCORE_EN is defined.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int          SCREEN_W = 640;
  localparam int          SCREEN_H = 480;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  // Digit-wise BCD compare, most significant digit decides first
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic result;
    logic decided;
    result  = 1'b0;
    decided = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      if (!decided && (a[4*d +: 4] != b[4*d +: 4])) begin
        result  = (a[4*d +: 4] > b[4*d +: 4]);
        decided = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit packed BCD increment that holds at 9999 and flags saturation.
module bcd_inc4
  import dino_pkg::*;
(
  input  logic [15:0] i_val,
  output logic [15:0] o_inc,
  output logic        o_sat
);

  logic [3:0] w_wrap;
  logic [3:0] w_carry;

  assign o_sat   = (i_val == BCD_MAX);
  assign w_carry = {&w_wrap[2:0], &w_wrap[1:0], w_wrap[0], 1'b1};

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      w_wrap[d] = (i_val[4*d +: 4] == 4'd9);
    end
  end

  // A digit rolls to 0 when it is 9 and a carry reaches it
  always_comb begin
    o_inc = i_val;
    if (!o_sat) begin
      for (int d = 0; d < 4; d++) begin
        if (w_carry[d]) begin
          o_inc[4*d +: 4] = w_wrap[d] ? 4'd0 : (i_val[4*d +: 4] + 4'd1);
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// IDLE/RUN/OVER controller: collision detect, score, speed ramp for the dino runner.
// Define GAME_CTRL_HISCORE_EN to add the hiscore output and its update logic.
module game_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT   = 6,
  parameter int unsigned SPEED_INIT         = 4,
  parameter int unsigned SPEED_MAX          = 12,
  parameter int unsigned POINTS_PER_SPEEDUP = 100
) (
  input  logic [31:0] clkdiv,
  input  logic        RESET,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        fresh,
  input  logic        cactus_px,
  input  logic        dino_px,
  input  logic        start_btn,
  output logic        game_status,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic        over
`ifdef GAME_CTRL_HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_fresh_d;
  logic        r_btn_d;
  logic        r_hit;
  logic [5:0]  r_frame_cnt;
  logic [9:0]  r_pts_cnt;
  logic [15:0] r_score;
  logic [3:0]  r_speed;
  logic        r_game_status;
  logic        r_over;

  logic        w_frame_tick;
  logic        w_start_pulse;
  logic        w_active;
  logic        w_collide;
  logic        w_start_game;
  logic        w_state_chg;
  logic        w_status_nxt;
  logic        w_over_nxt;
  logic [15:0] w_score_inc;
  logic        w_score_sat;
  logic        w_unused;

  assign w_unused      = ^clkdiv[31:1];
  assign w_frame_tick  = r_fresh_d & ~fresh;
  assign w_start_pulse = start_btn & ~r_btn_d;
  assign w_active      = (row_addr < 9'(SCREEN_H)) && (col_addr < 10'(SCREEN_W));
  assign w_collide     = cactus_px & dino_px & w_active & (r_state == RUN);
  assign w_start_game  = w_start_pulse & ((r_state == IDLE) | (r_state == OVER));
  assign w_state_chg   = (w_state_nxt != r_state);

  bcd_inc4 u_score_inc (
    .i_val (r_score),
    .o_inc (w_score_inc),
    .o_sat (w_score_sat)
  );

  always_ff @(posedge clkdiv[0]) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A collision only ends the game on a frame boundary so sprites freeze cleanly
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_pulse) w_state_nxt = RUN;
      RUN:     if (w_frame_tick && (r_hit || w_collide)) w_state_nxt = OVER;
      OVER:    if (w_start_pulse) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_status_nxt = (r_state == RUN);
    w_over_nxt   = (r_state == OVER);
  end

  always_ff @(posedge clkdiv[0]) begin
    if (RESET) begin
      r_fresh_d     <= 1'b0;
      r_btn_d       <= 1'b1;
      r_hit         <= 1'b0;
      r_frame_cnt   <= '0;
      r_pts_cnt     <= '0;
      r_score       <= 16'h0000;
      r_speed       <= 4'(SPEED_INIT);
      r_game_status <= 1'b0;
      r_over        <= 1'b0;
    end else begin
      r_fresh_d     <= fresh;
      r_btn_d       <= start_btn;
      r_game_status <= w_status_nxt;
      r_over        <= w_over_nxt;

      if (w_frame_tick || w_state_chg) begin
        r_hit <= 1'b0;
      end else if (w_collide) begin
        r_hit <= 1'b1;
      end

      if (w_start_game) begin
        r_score     <= 16'h0000;
        r_speed     <= 4'(SPEED_INIT);
        r_frame_cnt <= '0;
        r_pts_cnt   <= '0;
      end else if ((r_state == RUN) && w_frame_tick && !(r_hit || w_collide)) begin
        if (r_frame_cnt == 6'(FRAMES_PER_POINT - 1)) begin
          r_frame_cnt <= '0;
          // Once the score is pinned at 9999 the speed ramp stops too
          if (!w_score_sat) begin
            r_score <= w_score_inc;
            if (r_pts_cnt == 10'(POINTS_PER_SPEEDUP - 1)) begin
              r_pts_cnt <= '0;
              if (r_speed < 4'(SPEED_MAX)) begin
                r_speed <= r_speed + 4'd1;
              end
            end else begin
              r_pts_cnt <= r_pts_cnt + 10'd1;
            end
          end
        end else begin
          r_frame_cnt <= r_frame_cnt + 6'd1;
        end
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] r_hiscore;

  // Loaded on the edge that enters OVER, so it is already valid when over rises
  always_ff @(posedge clkdiv[0]) begin
    if (RESET) begin
      r_hiscore <= 16'h0000;
    end else if ((r_state == RUN) && (w_state_nxt == OVER) && bcd_gt(r_score, r_hiscore)) begin
      r_hiscore <= r_score;
    end
  end

  assign hiscore = r_hiscore;
`endif

  assign game_status = r_game_status;
  assign speed       = r_speed;
  assign score       = r_score;
  assign over        = r_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected outputs, a monitor compares on the falling clock.
// Build with GAME_CTRL_HISCORE_EN to also check the hiscore output.
module tb_game_ctrl;

  typedef struct {
    string       name;
    logic        expStatus;
    logic        expOver;
    logic [3:0]  expSpeed;
    logic [15:0] expScore;
    logic [15:0] expHi;
  } exp_t;

  logic [31:0] clkdiv;
  logic        RESET;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh;
  logic        cactus_px;
  logic        dino_px;
  logic        start_btn;
  logic        game_status;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        over;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hiscore;
`endif

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  game_ctrl #(
    .FRAMES_PER_POINT   (2),
    .SPEED_INIT         (4),
    .SPEED_MAX          (5),
    .POINTS_PER_SPEEDUP (2)
  ) dut (
    .clkdiv      (clkdiv),
    .RESET       (RESET),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .fresh       (fresh),
    .cactus_px   (cactus_px),
    .dino_px     (dino_px),
    .start_btn   (start_btn),
    .game_status (game_status),
    .speed       (speed),
    .score       (score),
    .over        (over)
`ifdef GAME_CTRL_HISCORE_EN
   ,.hiscore     (hiscore)
`endif
  );

  initial clkdiv = '0;
  always #5 clkdiv = clkdiv + 32'd1;

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clkdiv[0]);
      #1;
    end
  endtask

  // Each frame is one cycle of fresh high then one low; the tick lands on the low cycle
  task automatic applyStimulus(input int ticks);
    for (int i = 0; i < ticks; i++) begin
      fresh = 1'b1;
      settle(1);
      fresh = 1'b0;
      settle(1);
    end
  endtask

  task automatic setPixels(input logic [8:0] row, input logic [9:0] col, input logic px);
    row_addr  = row;
    col_addr  = col;
    cactus_px = px;
    dino_px   = px;
  endtask

  task automatic pressButton();
    start_btn = 1'b0;
    settle(1);
    start_btn = 1'b1;
    settle(1);
  endtask

  task automatic checkOutput(input string name, input logic expStatus, input logic expOver,
                             input logic [3:0] expSpeed, input logic [15:0] expScore,
                             input logic [15:0] expHi);
    exp_t e;
    e.name      = name;
    e.expStatus = expStatus;
    e.expOver   = expOver;
    e.expSpeed  = expSpeed;
    e.expScore  = expScore;
    e.expHi     = expHi;
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clkdiv[0]);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (game_status !== e.expStatus) begin
          errors++;
          $display("[TB] FAIL %s game_status got %0b want %0b", e.name, game_status, e.expStatus);
        end
        checks++;
        if (over !== e.expOver) begin
          errors++;
          $display("[TB] FAIL %s over got %0b want %0b", e.name, over, e.expOver);
        end
        checks++;
        if (speed !== e.expSpeed) begin
          errors++;
          $display("[TB] FAIL %s speed got %0d want %0d", e.name, speed, e.expSpeed);
        end
        checks++;
        if (score !== e.expScore) begin
          errors++;
          $display("[TB] FAIL %s score got %h want %h", e.name, score, e.expScore);
        end
`ifdef GAME_CTRL_HISCORE_EN
        checks++;
        if (hiscore !== e.expHi) begin
          errors++;
          $display("[TB] FAIL %s hiscore got %h want %h", e.name, hiscore, e.expHi);
        end
`endif
      end
    end
  end

  initial begin
    RESET     = 1'b1;
    start_btn = 1'b1;
    fresh     = 1'b0;
    setPixels(9'd0, 10'd0, 1'b0);
    settle(2);
    checkOutput("reset", 1'b0, 1'b0, 4'd4, 16'h0000, 16'h0000);

    // Button held through reset must not start a game
    RESET = 1'b0;
    applyStimulus(3);
    settle(1);
    checkOutput("idleHeld", 1'b0, 1'b0, 4'd4, 16'h0000, 16'h0000);

    $display("[TB] game 1: start and score");
    pressButton();
    settle(1);
    checkOutput("start", 1'b1, 1'b0, 4'd4, 16'h0000, 16'h0000);
    applyStimulus(2);
    settle(1);
    checkOutput("pt1", 1'b1, 1'b0, 4'd4, 16'h0001, 16'h0000);
    applyStimulus(2);
    settle(1);
    checkOutput("pt2", 1'b1, 1'b0, 4'd5, 16'h0002, 16'h0000);
    applyStimulus(56);
    settle(1);
    checkOutput("run60", 1'b1, 1'b0, 4'd5, 16'h0030, 16'h0000);

    $display("[TB] overlap outside the active area");
    setPixels(9'd500, 10'd100, 1'b1);
    applyStimulus(2);
    setPixels(9'd0, 10'd0, 1'b0);
    settle(1);
    checkOutput("row500", 1'b1, 1'b0, 4'd5, 16'h0031, 16'h0000);
    setPixels(9'd479, 10'd640, 1'b1);
    applyStimulus(2);
    setPixels(9'd0, 10'd0, 1'b0);
    settle(1);
    checkOutput("col640", 1'b1, 1'b0, 4'd5, 16'h0032, 16'h0000);
    setPixels(9'd480, 10'd639, 1'b1);
    applyStimulus(2);
    setPixels(9'd0, 10'd0, 1'b0);
    settle(1);
    checkOutput("row480", 1'b1, 1'b0, 4'd5, 16'h0033, 16'h0000);

    $display("[TB] mid-frame collision");
    applyStimulus(1);
    fresh = 1'b1;
    setPixels(9'd350, 10'd100, 1'b1);
    settle(1);
    setPixels(9'd0, 10'd0, 1'b0);
    settle(2);
    checkOutput("hitPending", 1'b1, 1'b0, 4'd5, 16'h0033, 16'h0000);
    fresh = 1'b0;
    settle(1);
    checkOutput("overLag", 1'b1, 1'b0, 4'd5, 16'h0033, 16'h0033);
    settle(1);
    checkOutput("over", 1'b0, 1'b1, 4'd5, 16'h0033, 16'h0033);
    applyStimulus(4);
    settle(1);
    checkOutput("overHold", 1'b0, 1'b1, 4'd5, 16'h0033, 16'h0033);

    $display("[TB] game 2: restart from OVER");
    pressButton();
    checkOutput("restartEdge", 1'b0, 1'b1, 4'd4, 16'h0000, 16'h0033);
    settle(1);
    checkOutput("restarted", 1'b1, 1'b0, 4'd4, 16'h0000, 16'h0033);
    applyStimulus(14);
    settle(1);
    checkOutput("g2run", 1'b1, 1'b0, 4'd5, 16'h0007, 16'h0033);
    fresh = 1'b1;
    settle(1);
    fresh = 1'b0;
    setPixels(9'd350, 10'd100, 1'b1);
    settle(1);
    setPixels(9'd0, 10'd0, 1'b0);
    settle(1);
    checkOutput("g2over", 1'b0, 1'b1, 4'd5, 16'h0007, 16'h0033);

    $display("[TB] game 3: saturation");
    pressButton();
    settle(1);
    checkOutput("g3start", 1'b1, 1'b0, 4'd4, 16'h0000, 16'h0033);
    applyStimulus(4);
    settle(1);
    checkOutput("g3pt2", 1'b1, 1'b0, 4'd5, 16'h0002, 16'h0033);
    pressButton();
    settle(1);
    checkOutput("startInRun", 1'b1, 1'b0, 4'd5, 16'h0002, 16'h0033);
    applyStimulus(19992);
    settle(1);
    checkOutput("near9998", 1'b1, 1'b0, 4'd5, 16'h9998, 16'h0033);
    applyStimulus(4);
    settle(1);
    checkOutput("sat9999", 1'b1, 1'b0, 4'd5, 16'h9999, 16'h0033);
    applyStimulus(6);
    settle(1);
    checkOutput("satHold", 1'b1, 1'b0, 4'd5, 16'h9999, 16'h0033);

    $display("[TB] reset during RUN");
    RESET = 1'b1;
    settle(1);
    checkOutput("resetRun", 1'b0, 1'b0, 4'd4, 16'h0000, 16'h0000);
    RESET = 1'b0;
    applyStimulus(2);
    settle(1);
    checkOutput("postReset", 1'b0, 1'b0, 4'd4, 16'h0000, 16'h0000);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      settle(1);
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending got %0d want 0", expQ.size());
    end
    @(negedge clkdiv[0]);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
